// File: rtl/apb_req_arbiter_if.sv
// Bundle of requester-side and APB-side signals for apb_req_arbiter.
// The "master" modport is the arbiter's view; "slave" is the environment's view.
interface apb_req_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        req_write;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ*STRB_W-1:0] req_strb;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        done;
  logic [DATA_W-1:0]      rsp_rdata;
  logic                   rsp_err;

  logic                   psel;
  logic                   penable;
  logic                   pwrite;
  logic [ADDR_W-1:0]      paddr;
  logic [DATA_W-1:0]      pwdata;
  logic [STRB_W-1:0]      pstrb;
  logic                   trnsfr;
  logic                   pready;
  logic                   pslverr;
  logic [DATA_W-1:0]      prdata;

  modport master (
    input  req, req_write, req_addr, req_wdata, req_strb,
    output gnt, done, rsp_rdata, rsp_err,
    output psel, penable, pwrite, paddr, pwdata, pstrb, trnsfr,
    input  pready, pslverr, prdata
  );

  modport slave (
    output req, req_write, req_addr, req_wdata, req_strb,
    input  gnt, done, rsp_rdata, rsp_err,
    input  psel, penable, pwrite, paddr, pwdata, pstrb, trnsfr,
    output pready, pslverr, prdata
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB slave among NREQ requesters, with
// SETUP/ACCESS sequencing, ACCESS watchdog and back-to-back hint.
module apb_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic               clk,
  input logic               rst,
  apb_req_arbiter_if.master bus
);
  localparam int STRB_W   = DATA_W / 8;
  localparam int PTR_W    = $clog2(NREQ);
  localparam int CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int CNT_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam int CNT_MAX  = (TIMEOUT > 0) ? TIMEOUT : 0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [STRB_W-1:0] pstrb_q, pstrb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [NREQ-1:0]   arb_req;
  logic              found;
  logic [PTR_W-1:0]  win;
  logic              load, go_idle;
  logic [NREQ-1:0]   done;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              trnsfr;

  // Rotating search starting at ptr+1; walking the offsets downwards lets the
  // nearest requester after the pointer overwrite any farther candidate.
  always_comb begin
    arb_req = '0;
    if (state_q == S_IDLE)        arb_req = bus.req;
    else if (state_q == S_ACCESS) arb_req = bus.req & ~gnt_q;
    found = 1'b0;
    win   = '0;
    for (int i = NREQ; i >= 1; i--) begin
      logic [PTR_W-1:0] idx;
      idx = PTR_W'((int'(ptr_q) + i) % NREQ);
      if (arb_req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    go_idle   = 1'b0;
    done      = '0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    trnsfr    = 1'b0;

    unique case (state_q)
      S_IDLE: load = found;
      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      S_ACCESS: begin
        if (bus.pready) begin
          done      = gnt_q;
          rsp_rdata = pwrite_q ? '0 : bus.prdata;
          rsp_err   = bus.pslverr;
          trnsfr    = found;
          load      = found;
          go_idle   = !found;
        end else if (TIMEOUT != 0 && cnt_q == CNT_W'(CNT_LAST)) begin
          done    = gnt_q;
          rsp_err = 1'b1;
          go_idle = 1'b1;
        end else if (cnt_q != CNT_W'(CNT_MAX)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: go_idle = 1'b1;
    endcase

    if (load) begin
      state_d   = S_SETUP;
      gnt_d     = NREQ'(1) << win;
      ptr_d     = win;
      psel_d    = 1'b1;
      penable_d = 1'b0;
      pwrite_d  = bus.req_write[win];
      paddr_d   = bus.req_addr[win*ADDR_W +: ADDR_W];
      pwdata_d  = bus.req_wdata[win*DATA_W +: DATA_W];
      pstrb_d   = bus.req_strb[win*STRB_W +: STRB_W];
    end else if (go_idle) begin
      state_d   = S_IDLE;
      gnt_d     = '0;
      psel_d    = 1'b0;
      penable_d = 1'b0;
      pwrite_d  = 1'b0;
      paddr_d   = '0;
      pwdata_d  = '0;
      pstrb_d   = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      ptr_q     <= PTR_W'(NREQ - 1);
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done;
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.rsp_err   = rsp_err;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.pstrb     = pstrb_q;
  assign bus.trnsfr    = trnsfr;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: inputs change on the falling edge and
// outputs are sampled 1 ns later, so every check sees one settled cycle.
module tb_apb_req_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TO   = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  apb_req_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_req_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [3:0] strb);
    bus.req[i]               = 1'b1;
    bus.req_write[i]         = wr;
    bus.req_addr[i*AW +: AW] = addr;
    bus.req_wdata[i*DW +: DW] = wdata;
    bus.req_strb[i*4 +: 4]   = strb;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req       = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_strb  = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    bus.prdata    = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    do_reset();
    #1;
    check("rst_psel", bus.psel, 0);
    check("rst_penable", bus.penable, 0);
    check("rst_gnt", bus.gnt, 0);
    check("rst_done", bus.done, 0);
    check("rst_trnsfr", bus.trnsfr, 0);
    check("rst_paddr", bus.paddr, 0);

    // Single write, zero wait states
    set_req(0, 1'b1, 32'h10, 32'hA5A5_A5A5, 4'hF);
    bus.pready = 1'b1;
    #1;
    check("wr_c0_psel", bus.psel, 0);
    next_cycle();
    check("wr_c1_psel", bus.psel, 1);
    check("wr_c1_penable", bus.penable, 0);
    check("wr_c1_gnt", bus.gnt, 4'b0001);
    check("wr_c1_paddr", bus.paddr, 32'h10);
    check("wr_c1_pwrite", bus.pwrite, 1);
    check("wr_c1_pwdata", bus.pwdata, 32'hA5A5_A5A5);
    check("wr_c1_done", bus.done, 0);
    next_cycle();
    check("wr_c2_penable", bus.penable, 1);
    check("wr_c2_done", bus.done, 4'b0001);
    check("wr_c2_err", bus.rsp_err, 0);
    check("wr_c2_paddr", bus.paddr, 32'h10);
    check("wr_c2_pstrb", bus.pstrb, 4'hF);
    check("wr_c2_trnsfr", bus.trnsfr, 0);
    bus.req[0] = 1'b0;
    next_cycle();
    check("wr_c3_psel", bus.psel, 0);
    check("wr_c3_gnt", bus.gnt, 0);
    check("wr_c3_paddr", bus.paddr, 0);

    // Round-robin with all four requesters held high
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 32'h100 + 32'(4 * i), '0, '0);
    bus.pready = 1'b1;
    bus.prdata = 32'hCAFE_0000;
    #1;
    check("rr_c0_psel", bus.psel, 0);
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      check("rr_setup_gnt", bus.gnt, 64'(4'b0001 << (k % 4)));
      check("rr_setup_penable", {bus.psel, bus.penable}, 2'b10);
      check("rr_setup_paddr", bus.paddr, 32'h100 + 32'(4 * (k % 4)));
      next_cycle();
      check("rr_access_done", bus.done, 64'(4'b0001 << (k % 4)));
      check("rr_access_penable", bus.penable, 1);
      check("rr_access_trnsfr", bus.trnsfr, 1);
      check("rr_access_rdata", bus.rsp_rdata, 32'hCAFE_0000);
    end
    bus.req = '0;
    #1;
    check("rr_last_trnsfr", bus.trnsfr, 0);
    next_cycle();
    check("rr_end_psel", bus.psel, 0);

    // Read with three wait states; requester fields change mid-transfer
    do_reset();
    set_req(2, 1'b0, 32'h20, '0, '0);
    bus.prdata = 32'h1234_5678;
    next_cycle();
    check("ws_c1_gnt", bus.gnt, 4'b0100);
    check("ws_c1_penable", bus.penable, 0);
    set_req(2, 1'b1, 32'hFFFF, 32'h1, 4'h1);
    for (int w = 0; w < 3; w++) begin
      next_cycle();
      check("ws_wait_done", bus.done, 0);
      check("ws_wait_penable", bus.penable, 1);
      check("ws_wait_paddr", bus.paddr, 32'h20);
      check("ws_wait_pwrite", bus.pwrite, 0);
      check("ws_wait_gnt", bus.gnt, 4'b0100);
    end
    @(negedge clk);
    bus.pready = 1'b1;
    #1;
    check("ws_c5_done", bus.done, 4'b0100);
    check("ws_c5_rdata", bus.rsp_rdata, 32'h1234_5678);
    check("ws_c5_err", bus.rsp_err, 0);
    bus.req = '0;
    next_cycle();
    check("ws_c6_psel", bus.psel, 0);

    // Slave error on a write, then a clean read from the next requester
    do_reset();
    set_req(0, 1'b1, 32'h40, 32'hDEAD, 4'hF);
    set_req(1, 1'b0, 32'h44, '0, '0);
    bus.pready  = 1'b1;
    bus.pslverr = 1'b1;
    bus.prdata  = 32'h55AA_55AA;
    next_cycle();
    check("err_c1_gnt", bus.gnt, 4'b0001);
    next_cycle();
    check("err_c2_done", bus.done, 4'b0001);
    check("err_c2_err", bus.rsp_err, 1);
    check("err_c2_rdata", bus.rsp_rdata, 0);
    check("err_c2_trnsfr", bus.trnsfr, 1);
    bus.req[0]  = 1'b0;
    bus.pslverr = 1'b0;
    next_cycle();
    check("err_c3_gnt", bus.gnt, 4'b0010);
    check("err_c3_paddr", bus.paddr, 32'h44);
    next_cycle();
    check("err_c4_done", bus.done, 4'b0010);
    check("err_c4_err", bus.rsp_err, 0);
    check("err_c4_rdata", bus.rsp_rdata, 32'h55AA_55AA);
    check("err_c4_trnsfr", bus.trnsfr, 0);
    bus.req = '0;
    next_cycle();
    check("err_c5_psel", bus.psel, 0);

    // Watchdog abort after TIMEOUT low-pready ACCESS cycles
    do_reset();
    set_req(3, 1'b0, 32'h80, '0, '0);
    bus.prdata = 32'h99;
    next_cycle();
    check("to_c1_gnt", bus.gnt, 4'b1000);
    for (int w = 0; w < 3; w++) begin
      next_cycle();
      check("to_wait_done", bus.done, 0);
    end
    next_cycle();
    check("to_c5_done", bus.done, 4'b1000);
    check("to_c5_err", bus.rsp_err, 1);
    check("to_c5_rdata", bus.rsp_rdata, 0);
    bus.req = '0;
    next_cycle();
    check("to_c6_psel", bus.psel, 0);
    check("to_c6_penable", bus.penable, 0);
    check("to_c6_gnt", bus.gnt, 0);

    // pready arriving in the timeout cycle wins
    do_reset();
    set_req(3, 1'b0, 32'h80, '0, '0);
    bus.prdata = 32'h99;
    repeat (4) next_cycle();
    check("tp_c4_done", bus.done, 0);
    @(negedge clk);
    bus.pready = 1'b1;
    #1;
    check("tp_c5_done", bus.done, 4'b1000);
    check("tp_c5_err", bus.rsp_err, 0);
    check("tp_c5_rdata", bus.rsp_rdata, 32'h99);
    bus.req = '0;
    next_cycle();
    check("tp_c6_psel", bus.psel, 0);

    // Async reset in ACCESS, then requester 0 regains priority
    do_reset();
    set_req(0, 1'b0, 32'h0, '0, '0);
    set_req(2, 1'b0, 32'h8, '0, '0);
    next_cycle();
    check("ar_c1_gnt", bus.gnt, 4'b0001);
    next_cycle();
    check("ar_c2_penable", bus.penable, 1);
    rst = 1'b1;
    #1;
    check("ar_rst_psel", bus.psel, 0);
    check("ar_rst_penable", bus.penable, 0);
    check("ar_rst_gnt", bus.gnt, 0);
    check("ar_rst_done", bus.done, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ar_rel_psel", bus.psel, 0);
    next_cycle();
    check("ar_rel_gnt", bus.gnt, 4'b0001);
    check("ar_rel_paddr", bus.paddr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
